ram_ctrl: RTL and testbench
===========================

// Module: ram_ctrl
// PURPOSE
//  Parametrised single-port data memory with valid/ready request and response channels.
//  Supports byte-enable writes, a configurable read latency, and alignment/range error reporting.
//  Clears its contents after reset. Serves as the CPU data-memory slave; one transaction outstanding.
// PARAMETERS
//  DWIDTH    32                   data width in bits; multiple of 8, >= 16
//  MEMDEPTH  256                  number of words
//  RD_LAT    1                    accept-to-response latency in cycles, 1..4
//  AWIDTH    $clog2(MEMDEPTH)     word-index width (derived)
//  OFFW      $clog2(DWIDTH/8)     byte-offset width (derived)
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  req_valid  in   1         request present
//  req_ready  out  1         request may be accepted
//  req_we     in   1         1 = write, 0 = read
//  req_addr   in   32        byte address
//  req_wdata  in   DWIDTH    write data
//  req_be     in   DWIDTH/8  byte enables; bit i -> wdata[8i+7:8i]
//  rsp_valid  out  1         response present
//  rsp_ready  in   1         consumer accepts response
//  rsp_rdata  out  DWIDTH    read data; 0 for writes and errors
//  rsp_err    out  1         misaligned or out-of-range access
// BEHAVIOUR
//  States: INIT -> IDLE -> WAIT -> RESP -> IDLE.
//  Reset state: INIT, init counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//  INIT: writes 0 to mem[cnt], one word per cycle, cnt 0..MEMDEPTH-1; -> IDLE after the last word (MEMDEPTH cycles).
//  rst_n asserted in any state (including mid-INIT) returns to INIT with cnt=0; the sweep restarts.
//  IDLE: req_ready=1. Accept on req_valid&&req_ready; latch we/addr/wdata/be; -> WAIT; req_ready=0 until return to IDLE.
//  Decode: idx=addr[OFFW+AWIDTH-1:OFFW]. err = addr[OFFW-1:0]!=0 OR addr[31:OFFW+AWIDTH]!=0.
//  Write (no err): mem updated on the accept edge; byte i written only if be[i]. be=0 is a legal no-op, err=0.
//  Read: mem sampled on the accept edge; value reflects all earlier completed writes.
//  err=1: no mem update; rdata=0.
//  WAIT: counts RD_LAT-1 cycles; with RD_LAT=1, the WAIT state is 0 cycles (accept -> RESP).
//  RESP: rsp_valid=1 exactly RD_LAT cycles after the accept edge, for both reads and writes.
//  rsp_rdata/rsp_err stable while rsp_valid && !rsp_ready.
//  Response completes on rsp_valid&&rsp_ready -> IDLE; rsp_valid=0 the next cycle.
//  req_ready=1 on the cycle after the response completes. Minimum turnaround: RD_LAT+1 cycles per transaction.
//  Requests are ignored during INIT/WAIT/RESP because req_ready=0; no queueing.
//  rsp_ready is ignored when rsp_valid=0.
// CONFIGURATION
//  RAM_BYTE_WRITE_EN defined:
//    byte-lane writes per req_be as above.
//  RAM_BYTE_WRITE_EN undefined:
//    req_be ignored; every error-free write updates the full word.
//    be=0 writes the full word.
//  Read and handshake behaviour are identical in both builds.
// TESTING
//  T1 reset: release rst_n -> req_ready=0 for exactly MEMDEPTH cycles, then 1; read any addr -> rdata=0, err=0.
//  T2 RD_LAT=2: write 0xDEADBEEF@0x10, be=4'hF; read 0x10 -> rsp_valid 2 cycles after accept, rdata=0xDEADBEEF.
//  T3 byte enables: write 0x11223344@0x20, then 0xAABBCCDD@0x20 with be=4'b0101.
//     Read -> 0x11BB33DD with RAM_BYTE_WRITE_EN defined, 0xAABBCCDD without it.
//  T4 errors: write to 0x22 -> err=1, mem unchanged; read from 0x400 (MEMDEPTH=256) -> err=1, rdata=0.
//  T5 backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rdata stable, req_ready=0; accepted on release.
//  T6 reset mid-op: assert rst_n low during WAIT, then during INIT at cnt=100.
//     Each time -> rsp_valid=0 immediately; full MEMDEPTH-cycle INIT resumes.

Source files
------------

// File: rtl/ram_ctrl.sv
// ram_ctrl: single-port data memory with valid/ready request and response
// channels, configurable read latency and alignment/range error reporting.
// The memory is cleared by an INIT sweep (one word per cycle) after reset.
// Optional build macro: RAM_BYTE_WRITE_EN -- when defined, writes honour
// req_be per byte lane; when undefined, every error-free write stores the
// full word and req_be is ignored.
module ram_ctrl #(
  parameter int DWIDTH   = 32,
  parameter int MEMDEPTH = 256,
  parameter int RD_LAT   = 1,
  parameter int AWIDTH   = $clog2(MEMDEPTH),
  parameter int OFFW     = $clog2(DWIDTH / 8)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [DWIDTH-1:0]   req_wdata,
  input  logic [DWIDTH/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DWIDTH-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NBYTES = DWIDTH / 8;
  localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(MEMDEPTH - 1);
  // WAIT holds for RD_LAT-1 cycles; the compare value is unreachable when RD_LAT=1
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 2);
  localparam bit HAS_WAIT = (RD_LAT > 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [AWIDTH-1:0]   init_cnt_r, init_cnt_s;
  logic [1:0]          wait_cnt_r, wait_cnt_s;
  logic                req_ready_r, req_ready_s;
  logic                rsp_valid_r, rsp_valid_s;
  logic                rsp_err_r, rsp_err_s;
  logic [DWIDTH-1:0]   rsp_rdata_r, rsp_rdata_s;

  logic                accept_s;
  logic                addr_err_s;
  logic [AWIDTH-1:0]   idx_s;
  logic [DWIDTH-1:0]   mem [MEMDEPTH];

  // Decode of the live request: word index, misalignment and out-of-range
  assign idx_s      = req_addr[OFFW+AWIDTH-1:OFFW];
  assign addr_err_s = (req_addr[OFFW-1:0] != {OFFW{1'b0}}) ||
                      ((req_addr >> (OFFW + AWIDTH)) != 32'd0);
  assign accept_s   = (state_r == ST_IDLE) && req_valid && req_ready_r;

`ifndef RAM_BYTE_WRITE_EN
  // Byte enables have no effect in the full-word build
  logic unused_be_s;
  assign unused_be_s = ^req_be;
`endif

  // Next-state and next-output logic; outputs are registered from these values
  always_comb begin
    state_s     = state_r;
    init_cnt_s  = init_cnt_r;
    wait_cnt_s  = wait_cnt_r;
    req_ready_s = req_ready_r;
    rsp_valid_s = rsp_valid_r;
    rsp_err_s   = rsp_err_r;
    rsp_rdata_s = rsp_rdata_r;
    case (state_r)
      ST_INIT: begin
        if (init_cnt_r == LAST_IDX) begin
          state_s     = ST_IDLE;
          init_cnt_s  = {AWIDTH{1'b0}};
          req_ready_s = 1'b1;
        end else begin
          init_cnt_s  = init_cnt_r + AWIDTH'(1);
        end
      end
      ST_IDLE: begin
        if (accept_s) begin
          req_ready_s = 1'b0;
          wait_cnt_s  = 2'd0;
          rsp_err_s   = addr_err_s;
          rsp_rdata_s = (!req_we && !addr_err_s) ? mem[idx_s] : {DWIDTH{1'b0}};
          if (HAS_WAIT) begin
            state_s     = ST_WAIT;
          end else begin
            state_s     = ST_RESP;
            rsp_valid_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_s     = ST_RESP;
          rsp_valid_s = 1'b1;
        end else begin
          wait_cnt_s  = wait_cnt_r + 2'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_s     = ST_IDLE;
          rsp_valid_s = 1'b0;
          req_ready_s = 1'b1;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s     = ST_INIT;
        init_cnt_s  = {AWIDTH{1'b0}};
        req_ready_s = 1'b0;
        rsp_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset restarts the clearing sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      init_cnt_r  <= {AWIDTH{1'b0}};
      wait_cnt_r  <= 2'd0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= {DWIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      init_cnt_r  <= init_cnt_s;
      wait_cnt_r  <= wait_cnt_s;
      req_ready_r <= req_ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_err_r   <= rsp_err_s;
      rsp_rdata_r <= rsp_rdata_s;
    end
  end

  // Memory array: zero sweep during INIT, error-free writes on the accept edge
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem[init_cnt_r] <= {DWIDTH{1'b0}};
    end else if (accept_s && req_we && !addr_err_s) begin
`ifdef RAM_BYTE_WRITE_EN
      for (int i = 0; i < NBYTES; i++) begin
        if (req_be[i]) begin
          mem[idx_s][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
`else
      mem[idx_s] <= req_wdata;
`endif
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: randomized and directed bench for ram_ctrl (RD_LAT=2,
// MEMDEPTH=256, DWIDTH=32) against a word-array reference model.
module tb_ram_ctrl;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks_cnt;
  int errors_cnt;

  logic [31:0] ref_mem [DEPTH];

  ram_ctrl #(.DWIDTH(32), .MEMDEPTH(DEPTH), .RD_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference write: applies byte lanes (or the full word) to the model
  task automatic model_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] w;
    w = ref_mem[addr / 4];
`ifdef RAM_BYTE_WRITE_EN
    for (int i = 0; i < 4; i++) begin
      if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
    end
`else
    w = wd;
`endif
    ref_mem[addr / 4] = w;
  endtask

  // Assert reset, check output values, release and measure the INIT sweep length
  task automatic reset_and_init(input string tag);
    int n;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    #1;
    check_eq({tag, "_rst_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check_eq({tag, "_rst_req_ready"}, 64'(req_ready), 64'd0);
    check_eq({tag, "_rst_rdata"}, 64'(rsp_rdata), 64'd0);
    check_eq({tag, "_rst_err"}, 64'(rsp_err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    n = 0;
    while (!req_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_init_cycles"}, 64'(n), 64'(DEPTH));
  endtask

  // One full transaction with a given number of backpressure cycles
  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input int stall);
    logic [31:0] exp_d;
    bit          exp_e;
    int          lat;
    int          n;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check_eq("ready_timeout", 64'(req_ready), 64'd1);
    exp_e = (addr % 4 != 0) || (addr / 4 >= DEPTH);
    exp_d = (!we && !exp_e) ? ref_mem[addr / 4] : 32'd0;
    if (we && !exp_e) model_write(addr, wd, be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom();
    req_wdata = $urandom();
    check_eq("ready_after_accept", 64'(req_ready), 64'd0);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 64'(lat), 64'(LAT));
    check_eq("rdata", 64'(rsp_rdata), 64'(exp_d));
    check_eq("err", 64'(rsp_err), 64'(exp_e));
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("stall_valid", 64'(rsp_valid), 64'd1);
      check_eq("stall_rdata", 64'(rsp_rdata), 64'(exp_d));
      check_eq("stall_err", 64'(rsp_err), 64'(exp_e));
      check_eq("stall_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("done_valid", 64'(rsp_valid), 64'd0);
    check_eq("done_ready", 64'(req_ready), 64'd1);
    rsp_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [31:0] a;
    int          sel;
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_be     = 4'd0;
    rsp_ready  = 1'b0;
    @(negedge clk);

    // T1: reset and INIT length, then cleared content
    reset_and_init("t1");
    txn(1'b0, 32'h0000_03FC, 32'd0, 4'h0, 0);

    // T2: full write and read back
    txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0);
    txn(1'b0, 32'h0000_0010, 32'd0, 4'h0, 0);
    check_eq("t2_direct", 64'(rsp_rdata), 64'h0000_0000_DEAD_BEEF);

    // T3: partial byte enables
    txn(1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 0);
    txn(1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 0);
    txn(1'b0, 32'h0000_0020, 32'd0, 4'h0, 0);
`ifdef RAM_BYTE_WRITE_EN
    check_eq("t3_direct", 64'(rsp_rdata), 64'h0000_0000_11BB_33DD);
`else
    check_eq("t3_direct", 64'(rsp_rdata), 64'h0000_0000_AABB_CCDD);
`endif

    // T4: misaligned write leaves memory alone, out-of-range read errors
    txn(1'b1, 32'h0000_0022, 32'h5555_5555, 4'hF, 0);
    check_eq("t4_wr_err", 64'(rsp_err), 64'd1);
    txn(1'b0, 32'h0000_0020, 32'd0, 4'h0, 0);
    txn(1'b0, 32'h0000_0400, 32'd0, 4'h0, 0);
    check_eq("t4_rd_err", 64'(rsp_err), 64'd1);

    // T5: response backpressure
    txn(1'b0, 32'h0000_0010, 32'd0, 4'h0, 5);

    // Randomized traffic
    for (int t = 0; t < 250; t++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 1) a = $urandom() | 32'h0000_0400;
      else a = 32'($urandom_range(0, 63)) << 2;
      txn(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)),
          $urandom_range(0, 3));
    end

    // T6a: reset while in WAIT
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010;
    @(negedge clk);
    req_valid = 1'b0;
    reset_and_init("t6_wait");
    txn(1'b0, 32'h0000_0010, 32'd0, 4'h0, 0);
    check_eq("t6_cleared", 64'(rsp_rdata), 64'd0);

    // T6b: reset while a response is held
    txn(1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, 0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("t6_resp_held", 64'(rsp_valid), 64'd1);
    reset_and_init("t6_resp");

    // T6c: reset in the middle of the INIT sweep
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check_eq("t6_mid_init_ready", 64'(req_ready), 64'd0);
    reset_and_init("t6_init");
    txn(1'b0, 32'h0000_0040, 32'd0, 4'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
